// File: rtl/pci_arb_if.sv
// pci_arb_if: active-low REQ/GNT handshake plus observed FRAME/IRDY shared with the arbiter
interface pci_arb_if #(
  parameter int NUM_MASTERS = 4,
  parameter int IDX_W = 2
);
  logic [NUM_MASTERS-1:0] req;
  logic [NUM_MASTERS-1:0] gnt;
  logic frame;
  logic irdy;
  logic [IDX_W-1:0] owner;
  logic timeout;
  modport master (output req, frame, irdy, input gnt, owner, timeout);
  modport slave (input req, frame, irdy, output gnt, owner, timeout);
endinterface

// File: rtl/pci_bus_arbiter.sv
// pci_bus_arbiter: round-robin central PCI arbiter with hidden arbitration and unused-grant timeout.
// Define PCI_ARB_PARK_EN to park the bus on master 0 while nobody requests.
module pci_bus_arbiter #(
  parameter int NUM_MASTERS = 4,
  parameter int IDLE_TIMEOUT = 16,
  parameter int IDX_W = 2
) (
  input logic clk,
  input logic rst_n,
  pci_arb_if.slave bus
);
  localparam int CW = $clog2(IDLE_TIMEOUT + 1);
  typedef enum logic [1:0] {IDLE, GRANTED, SWITCH} state_t;
  state_t state;
  logic [NUM_MASTERS-1:0] gnt;
  logic [IDX_W-1:0] owner, ptr, win;
  logic timeout, started, any_req, bus_idle, own_req, other_req, to_hit;
  logic [CW-1:0] idle_cnt;
  assign bus.gnt = gnt;
  assign bus.owner = owner;
  assign bus.timeout = timeout;
  assign any_req = ~&bus.req;
  assign bus_idle = bus.frame & bus.irdy;
  assign own_req = ~bus.req[owner];
  assign other_req = |(~bus.req & ~(NUM_MASTERS'(1) << owner));
  assign to_hit = !started && bus_idle && idle_cnt == CW'(IDLE_TIMEOUT - 1);
  // Search from ptr+1 so the last owner is considered only after everyone else.
  always_comb begin
    logic found;
    logic [IDX_W-1:0] idx;
    win = ptr;
    found = 1'b0;
    idx = '0;
    for (int i = 1; i <= NUM_MASTERS; i++) begin
      idx = IDX_W'((int'(ptr) + i) % NUM_MASTERS);
      if (!found && !bus.req[idx]) begin
        win = idx;
        found = 1'b1;
      end
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      gnt <= '1;
      owner <= '0;
      ptr <= IDX_W'(NUM_MASTERS - 1);
      timeout <= 1'b0;
      started <= 1'b0;
      idle_cnt <= '0;
    end else begin
      timeout <= 1'b0;
      case (state)
        IDLE: begin
`ifdef PCI_ARB_PARK_EN
          if (!gnt[0]) begin
            if (!bus.req[0]) begin
              state <= GRANTED;
              owner <= '0;
              ptr <= '0;
            end else if (any_req) begin
              gnt <= '1;
              state <= SWITCH;
            end
          end else if (any_req) begin
            gnt <= ~(NUM_MASTERS'(1) << win);
            owner <= win;
            ptr <= win;
            state <= GRANTED;
          end else begin
            gnt[0] <= 1'b0;
            owner <= '0;
          end
`else
          if (any_req) begin
            gnt <= ~(NUM_MASTERS'(1) << win);
            owner <= win;
            ptr <= win;
            state <= GRANTED;
          end
`endif
        end
        GRANTED: begin
          started <= started | ~bus.frame;
          idle_cnt <= (bus_idle && !started) ? idle_cnt + 1'b1 : '0;
          if (to_hit || (other_req && started) || (!own_req && (bus_idle || started))) begin
            gnt <= '1;
            state <= SWITCH;
            timeout <= to_hit;
            started <= 1'b0;
            idle_cnt <= '0;
          end
        end
        SWITCH: begin
          if (any_req) begin
            gnt <= ~(NUM_MASTERS'(1) << win);
            owner <= win;
            ptr <= win;
            state <= GRANTED;
          end else begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: doc/pci_bus_arbiter.md
Name: pci_bus_arbiter

Overview:
Central PCI arbiter that shares one PCI bus between NUM_MASTERS initiators using the active-low REQ/GNT handshake. It observes FRAME and IRDY to track bus activity and grants round-robin with hidden arbitration. Grants are removed on hand-over, on release, or on an unused-grant timeout. It sits beside the target devices on the shared AD/CBE/FRAME/IRDY bus and drives no bus lines itself.

Parameters:
NUM_MASTERS, 4, number of requesters (2..8)
IDLE_TIMEOUT, 16, consecutive idle-bus clocks a granted master may leave FRAME unasserted before the grant is revoked
IDX_W, 2, width of OWNER, equal to clog2(NUM_MASTERS)

Ports:
CLK  input  1  bus clock; all logic on rising edge
RST  input  1  asynchronous, active-low reset
REQ  input  NUM_MASTERS  active-low bus requests, one per master
FRAME  input  1  active-low PCI FRAME, observed only
IRDY  input  1  active-low PCI IRDY, observed only
GNT  output  NUM_MASTERS  active-low grants, registered
OWNER  output  IDX_W  index of the currently or last granted master
TIMEOUT  output  1  active-high, one-cycle pulse when a grant is revoked for non-use

Behaviour:
- Interface: one clock, CLK; reset RST is asynchronous, active-low.
- Reset (RST low, applied immediately, including mid-transaction):
  - GNT all 1, OWNER 0, TIMEOUT 0.
  - State IDLE, started flag 0, idle counter 0.
  - Round-robin pointer = NUM_MASTERS-1, so master 0 has highest priority first.
- Bus idle is defined as FRAME==1 && IRDY==1, sampled each edge.
- At most one GNT bit is low in any cycle; this is an invariant.
- Round-robin arbitration:
  - Search starts at pointer+1 and wraps modulo NUM_MASTERS.
  - On each new grant, the pointer becomes the granted index.
- State machine:
  - IDLE: if any REQ bit is sampled low at edge k, GNT[winner] goes low at edge k+1, OWNER=winner, next state GRANTED. One clock latency. Otherwise stay in IDLE.
  - GRANTED:
    - The started flag sets when FRAME is sampled low.
    - The idle counter increments on each idle-bus clock while started==0, and clears otherwise.
    - Leave to SWITCH, raising GNT[OWNER] at the same edge, when any of these holds:
      - (a) Another REQ is low and started==1. This is hidden arbitration; the owner finishes its current transaction.
      - (b) REQ[OWNER] is high and the bus is idle, or REQ[OWNER] is high and started==1.
      - (c) The idle counter reaches IDLE_TIMEOUT; TIMEOUT pulses for one cycle.
    - A lone requester holding REQ low keeps its grant indefinitely across back-to-back transactions.
    - If (a) and (c) are both true in the same cycle, (c) takes precedence and TIMEOUT still pulses.
  - SWITCH:
    - Exactly one clock with all GNT high; started and the counter clear.
    - Next edge: if any REQ is low, grant the round-robin winner (GRANTED); otherwise go to IDLE.
    - The previous owner may win again only if it is the sole requester.
    - The new GNT may assert while the previous transaction is still in progress. Waiting for bus idle is the master's responsibility.
- A REQ that is deasserted while in SWITCH is ignored at the next decision; only the REQ value sampled at that edge counts.
- OWNER holds its value through SWITCH and IDLE.

Optional Feature:
PCI_ARB_PARK_EN
- Defined:
  - In IDLE with no REQ low, GNT[0] is driven low (bus parked on master 0) from the clock after entering IDLE.
  - If master 0 requests while parked, the state becomes GRANTED with no extra cycle.
  - If another master requests while parked, GNT[0] is raised, followed by a SWITCH cycle, then the grant.
  - The parked master is not subject to the timeout.
- Undefined: all GNT stay high in IDLE.

Test Plan:
- Reset: hold RST low mid-grant → GNT=4'b1111, OWNER=0, TIMEOUT=0 immediately. Release, REQ=4'b1110 → GNT=4'b1110 one edge later.
- Round robin: REQ=4'b0000 continuously, each owner asserts FRAME for 3 clocks then deasserts REQ → grant order 0,1,2,3,0, one all-high clock between grants.
- Hidden arbitration: master 1 owns the bus with FRAME low, then REQ[2] falls → GNT[1] rises next edge, one SWITCH clock, GNT=4'b1011 while FRAME is still low.
- Timeout: grant master 3 with FRAME and IRDY held high for 16 clocks → GNT[3] rises, TIMEOUT pulses one cycle, master 0 (requesting) is granted after SWITCH.
- Lone requester: REQ=4'b1101 held for 3 back-to-back transactions → GNT=4'b1101 never deasserts, TIMEOUT stays 0.
- With PCI_ARB_PARK_EN defined: REQ=4'b1111 → GNT=4'b1110. Then REQ=4'b0111 → GNT=4'b1111 for one cycle, then 4'b0111.
